seq_mult8: RTL

//   Iterative shift-add unsigned multiplier for the datapath. Sits directly

---
 rtl/seq_mult8_if.sv | 25 ++
 rtl/seq_mult8.sv | 108 ++++++++++
 2 files changed

// File: rtl/seq_mult8_if.sv
// Handshake/result bundle between a requester and the seq_mult8 multiplier.
//   master: drives start/a/b and observes the product, busy, done and overflow.
//   slave : the multiplier side; receives the request and drives the results.
interface seq_mult8_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] product_lo;
  logic [WIDTH-1:0] product_hi;
  logic             busy;
  logic             done;
  logic             overflow;

  modport master (
    output start, a, b,
    input  product_lo, product_hi, busy, done, overflow
  );

  modport slave (
    input  start, a, b,
    output product_lo, product_hi, busy, done, overflow
  );
endinterface

// File: rtl/seq_mult8.sv
// Iterative shift-add unsigned multiplier, one add per cycle, WIDTH steps.
// Ports: clk, reset (sync, active-high), bus (slave modport: start/a/b in;
//   product_lo/product_hi/busy/done/overflow out, all registered).
// Latency: done one cycle after the last RUN step; throughput WIDTH+2 cycles.
module seq_mult8 #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  seq_mult8_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] product_lo_q;
  logic [WIDTH-1:0] product_hi_q;
  logic             busy_q;
  logic             done_q;
  logic             overflow_q;

  // One extra bit keeps the carry of acc + mcand so max*max stays exact.
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mplier_nxt;
  logic             last_step;

  always_comb begin
    sum        = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    // {acc,mplier} <= {sum,mplier} >> 1: carry lands in acc MSB, sum LSB
    // shifts into the vacated top of mplier.
    acc_nxt    = sum[WIDTH:1];
    mplier_nxt = {sum[0], mplier[WIDTH-1:1]};
    last_step  = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      count        <= '0;
      product_lo_q <= '0;
      product_hi_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mcand  <= bus.a;
            mplier <= bus.b;
            acc    <= '0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          acc    <= acc_nxt;
          mplier <= mplier_nxt;
          count  <= count + 1'b1;
          if (last_step) begin
            // Result registers take the final step's value directly so they
            // are valid in the same cycle that done is high.
            product_hi_q <= acc_nxt;
            product_lo_q <= mplier_nxt;
            overflow_q   <= (acc_nxt != '0);
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            state        <= DONE;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.product_lo = product_lo_q;
  assign bus.product_hi = product_hi_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;

endmodule
